// File: rtl/flicky_video_pkg.sv
// Shared timing constants, RGB332 field layout and the control word
// for the FLICKY video timing generator.
package flicky_video_pkg;

  localparam int H_TOTAL  = 384;
  localparam int H_VIS    = 256;
  localparam int HS_START = 288;
  localparam int HS_LEN   = 32;
  localparam int V_TOTAL  = 264;
  localparam int V_VIS    = 224;
  localparam int VS_START = 240;
  localparam int VS_LEN   = 3;
  localparam int PIX_LAT  = 2;

  // POUT is RGB332 packed as {B[7:6], G[5:3], R[2:0]}
  localparam int R_LSB = 0;
  localparam int R_W   = 3;
  localparam int G_LSB = 3;
  localparam int G_W   = 3;
  localparam int B_LSB = 6;
  localparam int B_W   = 2;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '0;

  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] lo,
                                     input logic [9:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/flicky_ctl_delay.sv
// Enable-gated shift register that carries the blank/sync control word
// alongside the video block's pixel pipeline.
module flicky_ctl_delay
  import flicky_video_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     en_i,
  input  vid_ctl_t d_i,
  output vid_ctl_t q_o
);

  vid_ctl_t stage_q [STAGES];

  // NOTE: the stages are plain flops, not a RAM, so they are reset; this keeps
  // blank/sync quiet until real control words have propagated through.
  // NOTE: non-blocking assignments let each stage take its neighbour's old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= CTL_IDLE;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/flicky_hvgen.sv
// FLICKY raster timing generator: 6 MHz pixel enable, PH/PV counters and a
// registered, blanked RGB output stage with syncs aligned to the pixel pipeline.
module flicky_hvgen
  import flicky_video_pkg::*;
#(
  parameter int P_H_TOTAL  = H_TOTAL,
  parameter int P_H_VIS    = H_VIS,
  parameter int P_HS_START = HS_START,
  parameter int P_HS_LEN   = HS_LEN,
  parameter int P_V_TOTAL  = V_TOTAL,
  parameter int P_V_VIS    = V_VIS,
  parameter int P_VS_START = VS_START,
  parameter int P_VS_LEN   = VS_LEN,
  parameter int PIX_LAT    = flicky_video_pkg::PIX_LAT
) (
  input  logic       clk48M,
  input  logic       reset,
  input  logic [3:0] hofs,
  input  logic [7:0] pix_in,
  output logic       ce_pix,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  logic [2:0] div_q, div_d;
  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;
  logic [3:0] hofs_q, hofs_d;
  logic [7:0] rgb_q, rgb_d;
  vid_ctl_t   ctl_q, ctl_d;
  vid_ctl_t   ctl_raw, ctl_dly;
  logic       ce, h_last, v_last;
  logic [9:0] hs_lo;

  assign ce     = (div_q == 3'd7);
  assign h_last = (ph_q == 9'(P_H_TOTAL - 1));
  assign v_last = (pv_q == 9'(P_V_TOTAL - 1));
  // hofs_q is signed; the sum stays non-negative for every legal offset
  assign hs_lo  = 10'(P_HS_START) + {{6{hofs_q[3]}}, hofs_q};

  always_comb begin
    ctl_raw.hblank = ({1'b0, ph_q} >= 10'(P_H_VIS));
    ctl_raw.vblank = ({1'b0, pv_q} >= 10'(P_V_VIS));
    ctl_raw.hsync  = in_window({1'b0, ph_q}, hs_lo, 10'(P_HS_LEN));
    ctl_raw.vsync  = in_window({1'b0, pv_q}, 10'(P_VS_START), 10'(P_VS_LEN));
  end

  flicky_ctl_delay #(
    .STAGES(PIX_LAT)
  ) u_ctl_delay (
    .clk_i(clk48M),
    .rst_i(reset),
    .en_i (ce),
    .d_i  (ctl_raw),
    .q_o  (ctl_dly)
  );

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    div_d  = div_q + 3'd1;
    ph_d   = ph_q;
    pv_d   = pv_q;
    hofs_d = hofs_q;
    ctl_d  = ctl_q;
    rgb_d  = rgb_q;
    if (ce) begin
      ph_d  = h_last ? '0 : ph_q + 9'd1;
      ctl_d = ctl_dly;
      rgb_d = (ctl_dly.hblank || ctl_dly.vblank) ? '0 : pix_in;
      if (h_last) begin
        pv_d = v_last ? '0 : pv_q + 9'd1;
        // frame start: the offset is only taken between frames
        if (v_last) hofs_d = hofs;
      end
    end
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      ph_q   <= '0;
      pv_q   <= '0;
      hofs_q <= '0;
      ctl_q  <= CTL_IDLE;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      pv_q   <= pv_d;
      hofs_q <= hofs_d;
      ctl_q  <= ctl_d;
      rgb_q  <= rgb_d;
    end
  end

  assign ce_pix = ce;
  assign PH     = ph_q;
  assign PV     = pv_q;
  assign hblank = ctl_q.hblank;
  assign vblank = ctl_q.vblank;
  assign hsync  = ctl_q.hsync;
  assign vsync  = ctl_q.vsync;
  assign red    = rgb_q[R_LSB +: R_W];
  assign green  = rgb_q[G_LSB +: G_W];
  assign blue   = rgb_q[B_LSB +: B_W];

endmodule

// File: tb/tb_flicky_hvgen.sv
// Self-checking bench for flicky_hvgen: an independent raster model feeds a
// scoreboard of expected blank/sync/RGB words, plus directed boundary checks.
module tb_flicky_hvgen;

  // Full horizontal timing; a short frame keeps whole-frame runs brief.
  localparam int H_TOTAL   = 384;
  localparam int H_VIS     = 256;
  localparam int HS_START  = 288;
  localparam int HS_LEN    = 32;
  localparam int V_TOTAL   = 6;
  localparam int V_VIS     = 4;
  localparam int VS_START  = 4;
  localparam int VS_LEN    = 1;
  localparam int PIX_LAT   = 2;
  localparam int LINE_CYC  = H_TOTAL * 8;
  localparam int FRAME_CYC = LINE_CYC * V_TOTAL;

  logic       clk48M = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] hofs   = 4'd0;
  logic [7:0] pix_in = 8'd0;
  logic       ce_pix, hblank, vblank, hsync, vsync;
  logic [8:0] PH, PV;
  logic [2:0] red, green;
  logic [1:0] blue;

  always #10 clk48M = ~clk48M;

  flicky_hvgen #(
    .P_H_TOTAL (H_TOTAL),
    .P_H_VIS   (H_VIS),
    .P_HS_START(HS_START),
    .P_HS_LEN  (HS_LEN),
    .P_V_TOTAL (V_TOTAL),
    .P_V_VIS   (V_VIS),
    .P_VS_START(VS_START),
    .P_VS_LEN  (VS_LEN),
    .PIX_LAT   (PIX_LAT)
  ) dut (
    .clk48M(clk48M),
    .reset (reset),
    .hofs  (hofs),
    .pix_in(pix_in),
    .ce_pix(ce_pix),
    .PH    (PH),
    .PV    (PV),
    .hblank(hblank),
    .vblank(vblank),
    .hsync (hsync),
    .vsync (vsync),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_ce = -1;
  logic        mon_en = 1'b0;
  logic [11:0] sb[$];
  int          ph_m, pv_m, hofs_m, pd1, pd2;
  int          c_a, c_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expect_pix(input int p, input int v, input int ho);
    logic hb, vb, hs, vs;
    logic [7:0] px;
    int lo;
    hb = (p >= H_VIS);
    vb = (v >= V_VIS);
    lo = HS_START + ho;
    hs = (p >= lo) && (p < lo + HS_LEN);
    vs = (v >= VS_START) && (v < VS_START + VS_LEN);
    px = p[7:0];
    if (hb || vb) px = '0;
    return {hb, vb, hs, vs, px[2:0], px[5:3], px[7:6]};
  endfunction

  // Runs at the negedge before each ce edge: checks counters, retires the
  // oldest expected word, queues the current pixel and drives pix_in.
  task automatic monitor();
    logic [11:0] obs_v, e;
    if (last_ce >= 0) check("ce_period", 32'(cyc - last_ce), 32'd8);
    last_ce = cyc;
    check("PH", 32'(PH), 32'(ph_m));
    check("PV", 32'(PV), 32'(pv_m));
    obs_v = {hblank, vblank, hsync, vsync, red, green, blue};
    if (sb.size() == PIX_LAT + 1) begin
      e = sb.pop_front();
      check($sformatf("pixel_%0d_%0d", ph_m, pv_m), 32'(obs_v), 32'(e));
    end
    sb.push_back(expect_pix(ph_m, pv_m, hofs_m));
    pix_in = 8'(pd2);
    pd2 = pd1;
    pd1 = ph_m;
    if (ph_m == H_TOTAL - 1) begin
      ph_m = 0;
      if (pv_m == V_TOTAL - 1) begin
        pv_m   = 0;
        hofs_m = int'($signed(hofs));
      end else begin
        pv_m++;
      end
    end else begin
      ph_m++;
    end
  endtask

  task automatic step();
    @(negedge clk48M);
    cyc++;
    if (mon_en && ce_pix) monitor();
  endtask

  task automatic wait_for(input int ph, input int pv);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(int'(PH) == ph && int'(PV) == pv) && n < 40000);
    check($sformatf("reach_%0d_%0d", ph, pv), 32'(int'(PH) == ph && int'(PV) == pv), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_PH"},  32'(PH), 32'd0);
    check({tag, "_PV"},  32'(PV), 32'd0);
    check({tag, "_ce"},  32'(ce_pix), 32'd0);
    check({tag, "_ctl"}, 32'({hblank, vblank, hsync, vsync}), 32'd0);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
  endtask

  // Releases reset away from an edge and checks the first ce_pix timing.
  task automatic startup();
    mon_en = 1'b0;
    pix_in = 8'd0;
    @(negedge clk48M);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk48M);
      #1;
      check($sformatf("ce_after_edge_%0d", i), 32'(ce_pix), 32'(i == 7));
    end
    @(posedge clk48M);
    #1;
    check("PH_after_8", 32'(PH), 32'd1);
    check("PV_after_8", 32'(PV), 32'd0);
    check("ce_after_8", 32'(ce_pix), 32'd0);
    check("ctl_after_8", 32'({hblank, vblank, hsync, vsync}), 32'd0);
    check("rgb_after_8", 32'({red, green, blue}), 32'd0);
    ph_m = 1; pv_m = 0; hofs_m = 0; pd1 = 0; pd2 = 0;
    sb.delete();
    last_ce = -1;
    mon_en  = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk48M);
    #1;
    check_all_zero("reset");
    startup();

    // RGB332 unpacking of a visible pixel, then blanking
    wait_for(168, 0);
    check("a5_red",   32'(red),   32'd5);
    check("a5_green", 32'(green), 32'd4);
    check("a5_blue",  32'(blue),  32'd2);
    wait_for(300, 0);
    check("blank_rgb",    32'({red, green, blue}), 32'd0);
    check("blank_hblank", 32'(hblank), 32'd1);

    wait_for(0, 1);
    c_a = cyc;
    wait_for(0, 2);
    check("line_period", 32'(cyc - c_a), 32'(LINE_CYC));

    // mid-frame offset change must not move this frame's sync
    wait_for(10, 2);
    hofs = 4'b1101;
    wait_for(290, 3);
    check("f0_hs_287", 32'(hsync), 32'd0);
    check("f0_vb_l3",  32'(vblank), 32'd0);
    wait_for(291, 3);
    check("f0_hs_288", 32'(hsync), 32'd1);
    wait_for(322, 3);
    check("f0_hs_319", 32'(hsync), 32'd1);
    wait_for(323, 3);
    check("f0_hs_320", 32'(hsync), 32'd0);
    wait_for(3, 4);
    check("vb_l4", 32'(vblank), 32'd1);
    check("vs_l4", 32'(vsync),  32'd1);
    wait_for(3, 5);
    check("vs_l5", 32'(vsync), 32'd0);

    wait_for(0, 0);
    c_a = cyc;
    wait_for(287, 1);
    check("f1_hs_284", 32'(hsync), 32'd0);
    wait_for(288, 1);
    check("f1_hs_285", 32'(hsync), 32'd1);
    wait_for(319, 1);
    check("f1_hs_316", 32'(hsync), 32'd1);
    wait_for(320, 1);
    check("f1_hs_317", 32'(hsync), 32'd0);
    wait_for(0, 0);
    c_b = cyc;
    check("frame_period", 32'(c_b - c_a), 32'(FRAME_CYC));

    // asynchronous reset in the middle of a visible line
    wait_for(200, 3);
    #3 reset = 1'b1;
    #1;
    check_all_zero("midrst");
    mon_en = 1'b0;
    repeat (3) @(posedge clk48M);
    startup();
    wait_for(168, 0);
    check("rst_a5_rgb", 32'({red, green, blue}), 32'({3'd5, 3'd4, 2'd2}));
    wait_for(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flicky_hvgen.md
# flicky_hvgen

Video timing generator and output stage for the FLICKY core. Sits directly upstream of the video block, supplying the PH/PV raster counters it consumes. Also sits downstream of it: it registers the returned 8-bit POUT pixel into blanked RGB with syncs aligned to the pixel pipeline, for the scan converter / VGA encoder. Derives its own 6 MHz pixel enable from clk48M, replacing the free-running clkdiv[2] pixel clock.

## Interface
- H_TOTAL, 384, pixels per line (PH counts 0..H_TOTAL-1)
- H_VIS, 256, visible pixels (PH 0..H_VIS-1)
- HS_START, 288, nominal HSYNC start pixel
- HS_LEN, 32, HSYNC width in pixels
- V_TOTAL, 264, lines per frame
- V_VIS, 224, visible lines
- VS_START, 240, VSYNC start line
- VS_LEN, 3, VSYNC width in lines
- PIX_LAT, 2, pixel-enable cycles from PH/PV to valid POUT at pix_in (1..4)

Ports:
- clk48M in 1 sole clock
- reset in 1 async, active-high
- hofs in 4 signed HSYNC shift (-8..+7 px), sampled at frame start
- pix_in in 8 POUT from video block, RGB332 {B[7:6],G[5:3],R[2:0]}
- ce_pix out 1 pixel enable, one clk48M cycle in 8
- PH out 9 horizontal counter
- PV out 9 vertical counter
- hblank out 1 PH ≥ H_VIS, pipeline-aligned
- vblank out 1 PV ≥ V_VIS, pipeline-aligned
- hsync out 1 active-high, pipeline-aligned
- vsync out 1 active-high, pipeline-aligned
- red out 3, green out 3, blue out 2, zero while blanked

## Operation
- 3-bit divider div increments every clk48M. ce_pix = (div == 7).
- On ce_pix: PH increments. At H_TOTAL-1, PH wraps to 0 and PV increments. PV wraps to 0 after V_TOTAL-1.
- Frame start is the ce_pix where PH and PV both wrap to 0. There, hofs is latched into hofs_q; mid-frame hofs changes are ignored.
- Raw HSYNC: PH in [HS_START+hofs_q, HS_START+hofs_q+HS_LEN). Sum computed in 10 bits, non-negative for all legal parameters.
- Raw VSYNC: PV in [VS_START, VS_START+VS_LEN).
- Raw hblank/vblank follow the PH/PV comparisons above.
- Delay line of PIX_LAT stages, advanced only on ce_pix, carries {hblank, vblank, hsync, vsync}.
- On ce_pix, RGB is registered from pix_in. If either delayed blank is set, RGB is forced to 0; otherwise red=pix_in[2:0], green=pix_in[5:3], blue=pix_in[7:6].
- All outputs change only in the clk48M cycle following a ce_pix, except ce_pix itself.

## Timing
- Reset (async assert, sync release): div=0, PH=0, PV=0, hofs_q=0.
- Delay-line stages reset to visible, no sync: hblank=vblank=hsync=vsync=0. RGB=0. ce_pix=0.
- First ce_pix occurs on the 8th rising edge after reset release. PH becomes 1 at that edge.
- Latency: the pixel addressed by PH/PV appears on RGB PIX_LAT+1 ce_pix later. Blank and sync for that PH/PV appear at the same edge.
- Line period 384×8 = 3072 clk48M cycles (15.625 kHz). Frame period 264 lines (59.19 Hz).
- Reset mid-frame: all state clears immediately. No partial-line recovery.
- Simultaneous H and V wrap resolves in one ce_pix: PH=0, PV=0.
- Sync intervals that reach H_TOTAL do not wrap. The legal hofs range keeps HSYNC within 280..327.

## Structure
- Package flicky_video_pkg holds: default timing constants (H_TOTAL, H_VIS, HS_*, V_TOTAL, V_VIS, VS_*), the RGB332 field positions, and a packed struct for the {hblank, vblank, hsync, vsync} control word.
- One sub-module, flicky_ctl_delay: a parameterised PIX_LAT-stage shift register with enable, instantiated for the control word.
- Counters, divider and RGB register stay in the top.

## Test plan
- Reset release, run 8 clk48M -> ce_pix high exactly on cycle 8. PH=1, PV=0, all sync/blank 0.
- Run one line -> PH wraps 383→0 and PV 0→1. hblank (after PIX_LAT+1 ce) high for exactly 128 pixels. hsync high pixels 288..319.
- Run full frame -> PV wraps 263→0. vblank high 40 lines. vsync high lines 240..242. Frame = 811008 clk48M cycles.
- hofs=-3 written mid-frame -> current frame sync still at 288. Next frame hsync at 285..316.
- pix_in driven as a function of PH (pix_in=PH[7:0] delayed PIX_LAT ce) -> at visible pixel 0xA5 output red=5, green=4, blue=2. During blank, RGB=0.
- Assert reset at PH=200, PV=100 for 3 cycles -> all outputs 0 asynchronously. Restart matches the first scenario.
